// File: rtl/asap_pkg.sv
// Shared types and constants for the ER execution monitor: FSM states,
// snapshot field layout and default counter widths.
package asap_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int FCNT_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_FAIL = 3'd4
    } state_t;

    // Snapshot layout: {done, fail, 2'b00, fail_cnt, run_cnt}; fail_cnt sits at SNAP_RUN_LSB + CNT_W
    localparam int SNAP_W       = 16;
    localparam int SNAP_DONE    = 15;
    localparam int SNAP_FAIL    = 14;
    localparam int SNAP_RUN_LSB = 0;

endpackage

// File: rtl/asap_sat_cnt.sv
// Saturating up-counter with increment enable; holds at all-ones, cleared only by reset.
module asap_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/asap_exec_monitor.sv
// ER execution monitor: tracks each ER run, latches done/fail, counts outcomes and
// serves a four-phase snapshot port. Optional ISR excursion tolerance: ASAP_IRQ_EXIT_EN.
module asap_exec_monitor
    import asap_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int FCNT_W = FCNT_W_DEF   // CNT_W + FCNT_W must not exceed 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        exec,
    input  logic        irq,
    input  logic [15:0] ER_min,
    input  logic [15:0] ER_max,
    input  logic [15:0] ER_exit,
    output logic        done,
    output logic        fail,
    input  logic        rpt_req,
    output logic        rpt_ack,
    output logic [15:0] rpt_data
);

    state_t state, state_nxt;

    logic              in_er;
    logic              excused;
    logic              enter;
    logic              inc_run;
    logic              inc_fail;
    logic [CNT_W-1:0]  run_cnt;
    logic [FCNT_W-1:0] fail_cnt;
    logic [15:0]       snap;

    assign in_er = (pc >= ER_min) && (pc <= ER_max);

`ifdef ASAP_IRQ_EXIT_EN
    logic irq_q;
    logic in_isr;

    // An excursion is tolerated if it starts while irq is (or just was) high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q  <= 1'b0;
            in_isr <= 1'b0;
        end else begin
            irq_q <= irq;
            if (state != ST_RUN || in_er)
                in_isr <= 1'b0;
            else if (irq || irq_q)
                in_isr <= 1'b1;
        end
    end

    assign excused = in_isr || irq || irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign excused    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL:
                if (pc == ER_min) state_nxt = ST_ARM;
            // exec lags pc by a cycle, so the entry fetch is validated here
            ST_ARM:
                state_nxt = exec ? ST_RUN : ST_FAIL;
            ST_RUN: begin
                if (!exec)
                    state_nxt = ST_FAIL;
                else if (!in_er && !excused)
                    state_nxt = ST_FAIL;
                else if (pc == ER_exit)
                    state_nxt = ST_DONE;
            end
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    assign enter    = (state_nxt != state);
    assign inc_run  = enter && (state_nxt == ST_DONE);
    assign inc_fail = enter && (state_nxt == ST_FAIL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            fail <= 1'b0;
        end else if (enter) begin
            case (state_nxt)
                ST_ARM: begin
                    done <= 1'b0;
                    fail <= 1'b0;
                end
                ST_DONE: done <= 1'b1;
                ST_FAIL: fail <= 1'b1;
                default: ;
            endcase
        end
    end

    asap_sat_cnt #(.W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_run),
        .cnt   (run_cnt)
    );

    asap_sat_cnt #(.W(FCNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_fail),
        .cnt   (fail_cnt)
    );

    always_comb begin
        snap                                   = '0;
        snap[SNAP_DONE]                        = done;
        snap[SNAP_FAIL]                        = fail;
        snap[SNAP_RUN_LSB +: CNT_W]            = run_cnt;
        snap[SNAP_RUN_LSB + CNT_W +: FCNT_W]   = fail_cnt;
    end

    // Capture uses pre-edge register values, so a same-edge state change reports old flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_ack  <= 1'b0;
            rpt_data <= '0;
        end else if (rpt_req && !rpt_ack) begin
            rpt_ack  <= 1'b1;
            rpt_data <= snap;
        end else if (!rpt_req) begin
            rpt_ack  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_asap_exec_monitor.sv
// Self-checking bench for asap_exec_monitor: per-scenario tasks plus a snapshot scoreboard.
module tb_asap_exec_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic        exec = 1'b0;
    logic        irq = 1'b0;
    logic [15:0] er_min = 16'hE000;
    logic [15:0] er_max = 16'hE0FF;
    logic [15:0] er_exit = 16'hE0F0;
    logic        rpt_req = 1'b0;
    logic        done, fail, rpt_ack;
    logic [15:0] rpt_data;

    int tests = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic        ack_prev = 1'b0;

    int m_run = 0;
    int m_fail = 0;
    bit m_done = 0;
    bit m_failf = 0;

    asap_exec_monitor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc),
        .exec     (exec),
        .irq      (irq),
        .ER_min   (er_min),
        .ER_max   (er_max),
        .ER_exit  (er_exit),
        .done     (done),
        .fail     (fail),
        .rpt_req  (rpt_req),
        .rpt_ack  (rpt_ack),
        .rpt_data (rpt_data)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rising rpt_ack pops one expected snapshot
    always @(posedge clk) begin
        #1;
        if (rpt_ack && !ack_prev) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL snapshot_unexpected got=%h required=none", rpt_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rpt_data !== e) begin
                    errors++;
                    $display("FAIL snapshot got=%h required=%h", rpt_data, e);
                end
            end
        end
        ack_prev = rpt_ack;
    end

    function automatic logic [15:0] exp_snap();
        logic [3:0] f;
        logic [7:0] r;
        f = 4'(m_fail);
        r = 8'(m_run);
        return {m_done, m_failf, 2'b00, f, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_done();
        m_done = 1; m_failf = 0;
        if (m_run < 255) m_run++;
    endtask

    task automatic model_fail();
        m_done = 0; m_failf = 1;
        if (m_fail < 15) m_fail++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; rpt_req = 1'b0; pc = 16'h0000; exec = 1'b0; irq = 1'b0;
        step(); step();
        rst_n = 1'b1;
        m_run = 0; m_fail = 0; m_done = 0; m_failf = 0;
    endtask

    // Enter the ER and pass the ARM check; leaves the DUT in RUN
    task automatic arm_run();
        pc = er_min; exec = 1'b0; step();
        pc = er_min + 16'h2; exec = 1'b1; step();
        m_done = 0; m_failf = 0;
    endtask

    task automatic do_run();
        arm_run();
        pc = er_exit; step();
        pc = 16'h0000; exec = 1'b0;
        model_done();
    endtask

    task automatic do_miss();
        pc = er_min; exec = 1'b0; step();
        pc = 16'h0000; step();
        model_fail();
    endtask

    task automatic req_snapshot(input logic [15:0] e);
        int n;
        exp_q.push_back(e);
        rpt_req = 1'b1;
        n = 0;
        while (!rpt_ack && n < 10) begin step(); n++; end
        if (!rpt_ack) begin
            tests++; errors++;
            $display("FAIL snapshot_ack_timeout got=0 required=1");
        end
        rpt_req = 1'b0;
        n = 0;
        while (rpt_ack && n < 10) begin step(); n++; end
        if (rpt_ack) begin
            tests++; errors++;
            $display("FAIL snapshot_ack_release got=1 required=0");
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({done, fail, rpt_ack} !== 3'b000 || rpt_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%b/%h required=000/0000", done, fail, rpt_ack, rpt_data);
        end
        req_snapshot(16'h0000);
    endtask

    task automatic test_clean_run();
        apply_reset();
        pc = 16'hE000; exec = 1'b0; step();
        pc = 16'hE002; exec = 1'b1; step();
        pc = 16'hE040; step();
        tests++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL clean_early_done got=%b required=0", done);
        end
        pc = 16'hE0F0; step();
        pc = 16'h0000; exec = 1'b0;
        model_done();
        tests++;
        if ({done, fail} !== 2'b10) begin
            errors++; $display("FAIL clean_flags got=%b%b required=10", done, fail);
        end
        req_snapshot(16'h8001);
    endtask

    task automatic test_write_abort();
        apply_reset();
        arm_run();
        pc = 16'hE00C; step();
        pc = 16'hE010; exec = 1'b0; step();
        pc = 16'h0000;
        model_fail();
        tests++;
        if ({done, fail} !== 2'b01) begin
            errors++; $display("FAIL abort_flags got=%b%b required=01", done, fail);
        end
        req_snapshot(16'h4100);
    endtask

    task automatic test_arm_miss();
        do_run();
        pc = er_min; exec = 1'b0; step();
        tests++;
        if ({done, fail} !== 2'b00) begin
            errors++; $display("FAIL arm_clear got=%b%b required=00", done, fail);
        end
        pc = 16'h0000; step();
        model_fail();
        tests++;
        if (fail !== 1'b1) begin
            errors++; $display("FAIL arm_miss got=%b required=1", fail);
        end
        req_snapshot(exp_snap());
    endtask

    task automatic test_exec_priority();
        arm_run();
        pc = er_exit; exec = 1'b0; step();
        pc = 16'h0000;
        model_fail();
        tests++;
        if ({done, fail} !== 2'b01) begin
            errors++; $display("FAIL exec_priority got=%b%b required=01", done, fail);
        end
    endtask

    task automatic test_early_exit();
        arm_run();
        pc = 16'hC000; irq = 1'b0; step();
        pc = 16'h0000; exec = 1'b0;
        model_fail();
        tests++;
        if (fail !== 1'b1) begin
            errors++; $display("FAIL early_exit got=%b required=1", fail);
        end
        arm_run();
        pc = 16'hC000; irq = 1'b1; step();
`ifdef ASAP_IRQ_EXIT_EN
        irq = 1'b0; pc = 16'hC004; step();
        tests++;
        if (fail !== 1'b0) begin
            errors++; $display("FAIL isr_excursion got=%b required=0", fail);
        end
        pc = 16'hE012; step();
        pc = er_exit; step();
        pc = 16'h0000; exec = 1'b0;
        model_done();
        tests++;
        if ({done, fail} !== 2'b10) begin
            errors++; $display("FAIL isr_return_done got=%b%b required=10", done, fail);
        end
`else
        irq = 1'b0; pc = 16'h0000; exec = 1'b0;
        model_fail();
        tests++;
        if (fail !== 1'b1) begin
            errors++; $display("FAIL irq_ignored got=%b required=1", fail);
        end
`endif
        req_snapshot(exp_snap());
    endtask

    task automatic test_range_bounds();
        arm_run();
        pc = er_max; step();
        pc = er_min; step();
        tests++;
        if ({done, fail} !== 2'b00) begin
            errors++; $display("FAIL bounds_max_loop got=%b%b required=00", done, fail);
        end
        pc = er_exit; step();
        pc = 16'h0000; exec = 1'b0;
        model_done();
        tests++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL bounds_loop_done got=%b required=1", done);
        end
        arm_run();
        pc = er_max + 16'h1; step();
        pc = 16'h0000; exec = 1'b0;
        model_fail();
        tests++;
        if (fail !== 1'b1) begin
            errors++; $display("FAIL bounds_above got=%b required=1", fail);
        end
        arm_run();
        pc = er_min - 16'h1; step();
        pc = 16'h0000; exec = 1'b0;
        model_fail();
        tests++;
        if (fail !== 1'b1) begin
            errors++; $display("FAIL bounds_below got=%b required=1", fail);
        end
        er_exit = 16'hF000;
        arm_run();
        pc = 16'hF000; step();
        pc = 16'h0000; exec = 1'b0;
        model_fail();
        tests++;
        if ({done, fail} !== 2'b01) begin
            errors++; $display("FAIL exit_outside got=%b%b required=01", done, fail);
        end
        er_exit = 16'hE0F0;
        req_snapshot(exp_snap());
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 260; i++) do_run();
        req_snapshot(16'h80FF);
        for (int i = 0; i < 20; i++) do_miss();
        req_snapshot(16'h4FFF);
    endtask

    task automatic test_handshake();
        apply_reset();
        do_run();
        arm_run();
        pc = er_exit; rpt_req = 1'b1;
        exp_q.push_back(16'h0001);
        step();
        pc = 16'h0000; exec = 1'b0;
        model_done();
        tests++;
        if (rpt_ack !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL hs_ack_rise got=%b/%b required=1/1", rpt_ack, done);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) do_run();
            step();
            tests++;
            if (rpt_ack !== 1'b1 || rpt_data !== 16'h0001) begin
                errors++; $display("FAIL hs_hold got=%b/%h required=1/0001", rpt_ack, rpt_data);
            end
        end
        rpt_req = 1'b0;
        #1;
        tests++;
        if (rpt_ack !== 1'b1) begin
            errors++; $display("FAIL hs_ack_early_fall got=%b required=1", rpt_ack);
        end
        step();
        tests++;
        if (rpt_ack !== 1'b0 || rpt_data !== 16'h0001) begin
            errors++; $display("FAIL hs_ack_fall got=%b/%h required=0/0001", rpt_ack, rpt_data);
        end
        req_snapshot(exp_snap());
    endtask

    task automatic test_reset_midrun();
        do_run();
        req_snapshot(exp_snap());
        arm_run();
        pc = 16'hE010;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({done, fail, rpt_ack} !== 3'b000 || rpt_data !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_reset got=%b%b%b/%h required=000/0000", done, fail, rpt_ack, rpt_data);
        end
        step();
        rst_n = 1'b1;
        m_run = 0; m_fail = 0; m_done = 0; m_failf = 0;
        pc = er_exit; exec = 1'b1; step();
        pc = 16'h0000; exec = 1'b0; step();
        tests++;
        if ({done, fail} !== 2'b00) begin
            errors++; $display("FAIL midrun_idle got=%b%b required=00", done, fail);
        end
        req_snapshot(16'h0000);
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_write_abort();
        test_arm_miss();
        test_exec_priority();
        test_early_exit();
        test_range_bounds();
        test_saturation();
        test_handshake();
        test_reset_midrun();
        step(); step();
        tests++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/asap_exec_monitor.md
# asap_exec_monitor

Tracks each execution of the attested Executable Region (ER) and decides whether it completed cleanly. Sits directly downstream of the ER immutability checker and consumes its registered `exec` flag together with the CPU `pc`. Produces a latched done/fail verdict and saturating run/fail counters. The attestation engine reads these as a snapshot over a four-phase request/acknowledge port.

## Interface
- `CNT_W`, 8 — width of the successful-run counter.
- `FCNT_W`, 4 — width of the failure counter; `CNT_W + FCNT_W` must be ≤ 12.
- `clk  in  1  system clock; single clock domain`
- `rst_n  in  1  reset; asynchronous, active-low`
- `pc  in  16  current CPU program counter`
- `exec  in  1  registered exec flag from the immutability checker; lags pc by one cycle`
- `irq  in  1  CPU interrupt-taken indication`
- `ER_min  in  16  first ER instruction address`
- `ER_max  in  16  last ER byte address`
- `ER_exit  in  16  address of the ER's final instruction`
- `done  out  1  last execution completed cleanly`
- `fail  out  1  last execution aborted or violated`
- `rpt_req  in  1  snapshot request, level`
- `rpt_ack  out  1  snapshot acknowledge, level`
- `rpt_data  out  16  snapshot {done, fail, 2'b00, fail_cnt, run_cnt}, zero-padded to the used widths`

## Operation
- States: IDLE, ARM, RUN, DONE, FAIL. Encoded as 3 bits.
- IDLE, DONE, FAIL: `pc == ER_min` → ARM. Entering ARM clears `done` and `fail`.
- ARM: exactly one cycle.
  - `exec` = 1 → RUN.
  - `exec` = 0 → FAIL.
  - Reason: `exec` lags `pc` by one cycle, so it is checked in ARM, not at entry.
- RUN, checked in priority order:
  1. `exec` = 0 → FAIL.
  2. `pc` outside [ER_min, ER_max] → FAIL, unless excused by the Configuration feature.
  3. `pc == ER_exit` → DONE.
- Entering DONE: set `done`; `run_cnt` += 1, saturating at all-ones.
- Entering FAIL: set `fail`; `fail_cnt` += 1, saturating at all-ones.
- `pc == ER_min` while in RUN is a legal loop back to the entry point. It stays in RUN and is not re-armed.
- Report port, four-phase handshake:
  - `rpt_req` = 1 with `rpt_ack` = 0: on the next edge, capture `rpt_data` and set `rpt_ack` = 1.
  - `rpt_ack` stays 1 until `rpt_req` = 0. It falls on the edge after that.
  - `rpt_data` holds its value between captures.
  - The snapshot reflects register values *before* any state update on the same edge.
- Counters are never cleared except by reset.

## Timing
- Reset values: state IDLE, `done` 0, `fail` 0, `rpt_ack` 0, `rpt_data` 0, counters 0.
- Reset asserted mid-run forces IDLE immediately, asynchronously; no fail is recorded.
- All outputs are registered. A state change and its flags/counters become visible on the edge after the qualifying inputs.
- Latency from `pc == ER_min` to RUN is 2 edges (IDLE→ARM, ARM→RUN).
- Simultaneous events:
  - `exec` = 0 with `pc == ER_exit` → FAIL (exec has priority).
  - A capture on the edge of a state change reports the old flags.
- If `ER_exit` lies outside [ER_min, ER_max], the run FAILs by range before DONE can occur.
- Counter wrap is forbidden. At all-ones the counter holds.

## Configuration
- `ASAP_IRQ_EXIT_EN` defined:
  - In RUN, when `pc` leaves the ER in a cycle where `irq` = 1 (or `irq` was 1 the previous cycle), an internal `in_isr` bit is set.
  - While `in_isr` = 1, an out-of-ER `pc` is not a violation.
  - `pc` back in [ER_min, ER_max] clears `in_isr`.
  - `exec` = 0 still FAILs during the ISR.
- `ASAP_IRQ_EXIT_EN` undefined: any out-of-ER `pc` in RUN → FAIL. `irq` is ignored and `in_isr` is not implemented.

## Structure
- Shared package `asap_pkg` holds:
  - the state enum/localparams;
  - the snapshot field offsets;
  - the default `CNT_W` and `FCNT_W`.
- Natural sub-module: `asap_sat_cnt`, a parameterised saturating counter with an increment enable. It is instantiated twice, for runs and for fails.
- Range compare, FSM and report handshake stay in the top level.

## Test plan
- Clean run:
  - Stimulus: ER_min=E000, ER_max=E0FF, ER_exit=E0F0; pc E000 then `exec`=1, pc steps to E0F0.
  - Response: `done`=1, `fail`=0, `run_cnt`=1; snapshot reads 0x8001.
- Write abort:
  - Stimulus: `exec` drops at pc=E010 mid-run.
  - Response: FAIL, `fail_cnt`=1; `done` stays 0; snapshot reads 0x4100.
- ARM miss:
  - Stimulus: pc=E000, but `exec`=0 in the next cycle.
  - Response: FAIL two edges later.
- Early exit:
  - Stimulus: pc jumps to C000 from RUN with `irq`=0.
  - Response: FAIL.
  - Also with `ASAP_IRQ_EXIT_EN`, `irq`=1 and return to E012: stays RUN, then reaches DONE.
- Saturation:
  - Stimulus: 260 clean runs.
  - Response: `run_cnt`=FF, snapshot reads 0x80FF.
  - Also 20 fails: `fail_cnt`=F.
- Handshake and reset:
  - Stimulus: `rpt_req` held for 5 cycles.
  - Response: a single capture; `rpt_ack` falls one edge after `rpt_req` falls.
  - Also `rst_n` pulsed low mid-RUN: all outputs 0 and IDLE immediately.
